// File: rtl/serial_add3_pkg.sv
// ----------------------------------------------------------------------------
// serial_add3_pkg
// Definitions shared by serial_add3_acc and its bench:
//   state_e         : controller states (IDLE, SHIFT, DONE)
//   res_width(w)    : result width for a w-bit three-operand sum (w+2)
//   cnt_width(w)    : width of the bit counter, $clog2(w+3)
// ----------------------------------------------------------------------------
package serial_add3_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Three w-bit operands plus a carry-in of 1 sum to at most 3*(2^w-1)+1,
    // which needs w+2 bits.
    function automatic int res_width(input int w);
        return w + 2;
    endfunction

    // The counter has to hold the values 0 .. w+1.
    function automatic int cnt_width(input int w);
        return $clog2(w + 3);
    endfunction

endpackage

// File: rtl/serial_add3_acc_bit_slice.sv
// ----------------------------------------------------------------------------
// add3_bit_slice
// Combinational three-input full-adder slice with a 2-bit carry.
// Ports:
//   a, b, c : operand bits
//   cin     : incoming carry, range 0..2
//   s       : sum bit, the LSB of a+b+c+cin
//   cout    : outgoing carry, (a+b+c+cin) >> 1, range 0..2
// ----------------------------------------------------------------------------
module add3_bit_slice (
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic [1:0] cin,
    output logic       s,
    output logic [1:0] cout
);

    logic [2:0] t;

    // t ranges from 0 to 5, so three bits are enough.
    always_comb begin
        t    = {2'b00, a} + {2'b00, b} + {2'b00, c} + {1'b0, cin};
        s    = t[0];
        cout = t[2:1];
    end

endmodule

// File: rtl/serial_add3_acc.sv
// ----------------------------------------------------------------------------
// serial_add3_acc
// Bit-serial three-operand adder. It accepts a triple (a, b, c) in one
// valid/ready transfer and runs it LSB-first through add3_bit_slice, one bit
// per cycle, with the carry held in a register. After WIDTH+2 bits it
// presents the WIDTH+2-bit sum on a valid/ready output port.
//
// Parameters:
//   WIDTH      : operand width in bits (>= 2)
// Ports:
//   clk        : clock, rising edge
//   reset      : synchronous, active-high reset
//   in_valid   : operand triple valid
//   in_ready   : block can accept a triple (IDLE only)
//   in_a/b/c   : unsigned operands, sampled on the accept edge
//   in_cin     : carry-in, only when SERIAL_ADD3_ACC_CIN_EN is defined
//   out_valid  : result valid (DONE)
//   out_ready  : consumer accepts the result
//   out_sum    : registered sum, stable while out_valid is high
//   busy       : high while bits are being shifted (SHIFT)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The input side is ready only in IDLE. The output side holds valid
// in DONE until out_ready is high on a rising edge. The two sides never
// overlap.
//
// Optional feature: when SERIAL_ADD3_ACC_CIN_EN is defined, the block adds an
// in_cin port. Its value is loaded as the initial carry.
// ----------------------------------------------------------------------------
module serial_add3_acc
    import serial_add3_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic [WIDTH-1:0]   in_c,
`ifdef SERIAL_ADD3_ACC_CIN_EN
    input  logic               in_cin,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH+1:0]   out_sum,
    output logic               busy
);

    localparam int RW = res_width(WIDTH);
    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(RW - 1);

    state_e          state_q, state_d;
    logic [RW-1:0]   a_q, b_q, c_q;
    logic [RW-1:0]   sum_q;
    logic [1:0]      carry_q;
    logic [CW-1:0]   cnt_q;

    logic            slice_s;
    logic [1:0]      slice_cout;
    logic [1:0]      init_carry;

`ifdef SERIAL_ADD3_ACC_CIN_EN
    assign init_carry = {1'b0, in_cin};
`else
    assign init_carry = 2'b00;
`endif

    add3_bit_slice u_slice (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .c    (c_q[0]),
        .cin  (carry_q),
        .s    (slice_s),
        .cout (slice_cout)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state and outputs ----------------
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = SHIFT;
            end
            SHIFT: begin
                busy = 1'b1;
                // cnt_q counts SHIFT edges that have already happened, so
                // this edge is number RW.
                if (cnt_q == LAST_BIT) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            sum_q   <= '0;
            carry_q <= 2'b00;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= {2'b00, in_a};
                        b_q     <= {2'b00, in_b};
                        c_q     <= {2'b00, in_c};
                        carry_q <= init_carry;
                        cnt_q   <= '0;
                    end
                end
                SHIFT: begin
                    // Result bits enter at the MSB. After RW shifts the first
                    // (LSB) bit has reached bit 0.
                    sum_q   <= {slice_s, sum_q[RW-1:1]};
                    carry_q <= slice_cout;
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    c_q     <= c_q >> 1;
                    cnt_q   <= cnt_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign out_sum = sum_q;

endmodule

// File: tb/tb_serial_add3_acc.sv
// Bench for serial_add3_acc, WIDTH=8. Expected sums come from plain integer
// addition. Latency, busy length, stability under backpressure, masking of
// in_valid and reset mid-operation are checked with directed sequences.
module tb_serial_add3_acc;
    import serial_add3_pkg::*;

    localparam int W  = 8;
    localparam int RW = W + 2;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a, in_b, in_c;
    logic          in_cin;
    logic          out_valid;
    logic          out_ready;
    logic [RW-1:0] out_sum;
    logic          busy;

    int n_vec;
    int n_err;

    serial_add3_acc #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_c      (in_c),
`ifdef SERIAL_ADD3_ACC_CIN_EN
        .in_cin    (in_cin),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .busy      (busy)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model: the specification's arithmetic, nothing more.
    function automatic int model_sum(input int a, input int b, input int c, input int cin);
`ifdef SERIAL_ADD3_ACC_CIN_EN
        return a + b + c + cin;
`else
        return a + b + c + 0 * cin;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction. Drives a triple from IDLE, waits for out_valid
    // (bounded), holds out_ready low for 'hold' cycles checking stability,
    // then completes the handshake. When 'mask' is set, in_valid stays high
    // with junk operands for the whole transaction.
    task automatic txn(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] c, input logic cin_v,
                       input int hold, input bit mask,
                       output int got, output int lat, output int busy_n);
        logic [RW-1:0] first_sum;
        check("in_ready_before_accept", int'(in_ready), 1);
        in_a = a; in_b = b; in_c = c; in_cin = cin_v;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        tick();
        if (!mask) in_valid = 1'b0;
        lat = 0;
        busy_n = 0;
        while (!out_valid && lat < 100) begin
            if (busy) busy_n++;
            if (mask) begin
                in_a = W'($urandom); in_b = W'($urandom);
                in_c = W'($urandom); in_cin = 1'($urandom);
                if (in_ready) begin
                    n_vec++; n_err++;
                    $display("FAIL in_ready_busy: got 1, expected 0");
                end
            end
            tick();
            lat++;
        end
        if (!out_valid) begin
            n_vec++; n_err++;
            $display("FAIL out_valid_timeout: got 0 after %0d cycles, expected 1", lat);
            got = -1;
            in_valid = 1'b0;
            return;
        end
        check("final_carry_zero", int'(dut.carry_q), 0);
        check("in_ready_in_done", int'(in_ready), 0);
        first_sum = out_sum;
        for (int i = 0; i < hold; i++) begin
            tick();
            check("out_valid_hold", int'(out_valid), 1);
            check("out_sum_stable", int'(out_sum), int'(first_sum));
        end
        got = int'(out_sum);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("out_valid_after_hs", int'(out_valid), 0);
        check("in_ready_after_hs", int'(in_ready), 1);
    endtask

    typedef struct {
        logic [W-1:0]  a, b, c;
        logic          cin;
        int            hold;
        int            exp;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int got, lat, busy_n, exp;
        logic [W-1:0] ra, rb, rc;
        logic rcin;

        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_c = '0; in_cin = 1'b0;

        vecs[0] = '{a: 8'd1,   b: 8'd2,   c: 8'd3,   cin: 1'b0, hold: 0, exp: 6};
        vecs[1] = '{a: 8'd255, b: 8'd255, c: 8'd255, cin: 1'b0, hold: 0, exp: 765};
        vecs[2] = '{a: 8'd0,   b: 8'd0,   c: 8'd0,   cin: 1'b0, hold: 1, exp: 0};
        vecs[3] = '{a: 8'd100, b: 8'd50,  c: 8'd7,   cin: 1'b0, hold: 5, exp: 157};
        vecs[4] = '{a: 8'd128, b: 8'd128, c: 8'd128, cin: 1'b0, hold: 2, exp: 384};
        vecs[5] = '{a: 8'd255, b: 8'd0,   c: 8'd1,   cin: 1'b0, hold: 0, exp: 256};
        vecs[6] = '{a: 8'd85,  b: 8'd170, c: 8'd255, cin: 1'b0, hold: 3, exp: 510};

        // ---------------- reset state ----------------
        tick(); tick();
        reset = 1'b0;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_out_sum", int'(out_sum), 0);
        check("rst_state", int'(dut.state_q), int'(IDLE));

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < 7; i++) begin
            txn(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].cin, vecs[i].hold,
                (i == 3), got, lat, busy_n);
            check($sformatf("vec%0d_sum", i), got, vecs[i].exp);
            check($sformatf("vec%0d_latency", i), lat, RW);
            check($sformatf("vec%0d_busy_cycles", i), busy_n, RW);
        end

`ifdef SERIAL_ADD3_ACC_CIN_EN
        txn(8'd255, 8'd255, 8'd255, 1'b1, 0, 1'b0, got, lat, busy_n);
        check("cin_max_sum", got, 766);
`endif

        // ---------------- reset mid-SHIFT ----------------
        in_a = 8'd200; in_b = 8'd201; in_c = 8'd202;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("mid_busy_before_reset", int'(busy), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_state", int'(dut.state_q), int'(IDLE));
        check("mid_rst_out_valid", int'(out_valid), 0);
        check("mid_rst_out_sum", int'(out_sum), 0);
        check("mid_rst_in_ready", int'(in_ready), 1);
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid) begin
                n_vec++; n_err++;
                $display("FAIL mid_rst_no_valid: got 1, expected 0");
            end
        end
        txn(8'd10, 8'd20, 8'd30, 1'b0, 0, 1'b0, got, lat, busy_n);
        check("after_rst_sum", got, 60);

        // ---------------- reset in DONE ----------------
        in_a = 8'd9; in_b = 8'd9; in_c = 8'd9;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < RW; i++) tick();
        check("done_before_reset", int'(out_valid), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("done_rst_out_valid", int'(out_valid), 0);
        check("done_rst_out_sum", int'(out_sum), 0);

        // ---------------- randomized against the model ----------------
        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom); rb = W'($urandom); rc = W'($urandom);
            rcin = 1'($urandom);
            if (i == 0) begin ra = '1; rb = '1; rc = '1; end
            exp = model_sum(int'(ra), int'(rb), int'(rc), int'(rcin));
            txn(ra, rb, rc, rcin, $urandom_range(0, 3), 1'($urandom),
                got, lat, busy_n);
            check($sformatf("rand%0d_sum", i), got, exp);
            check($sformatf("rand%0d_latency", i), lat, RW);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $finish;
    end

endmodule
